// File: rtl/lcd_pkg.sv
// Shared types and screen geometry for the LCD pixel feeder.
package lcd_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int POS_W    = 18;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic    sof;
    rgb888_t rgb;
  } pix_entry_t;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_WAIT_SOF  = 2'd1,
    ST_STREAM    = 2'd2,
    ST_PAD       = 2'd3
  } feeder_state_e;

  // Frame position advance with wrap at the last pixel of the frame.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input logic [POS_W-1:0] last);
    return (pos == last) ? 18'd0 : pos + 18'd1;
  endfunction

endpackage

// File: rtl/lcd_pixel_feeder_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry sits in a register and is valid
// whenever empty_o is low. Writes while full are dropped; reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == (AW+1)'(0));
  assign wr_ok      = wr_en_i & ~full_o;
  assign rd_ok      = rd_en_i & ~empty_o;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign rd_data_o  = rd_data_q;

  // Next head: the following stored entry, or the incoming word when it lands in an empty slot.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_ok) begin
      if (count_q == (AW+1)'(1)) rd_data_d = wr_data_i;
      else                       rd_data_d = mem_q[rd_ptr_nxt];
    end else if (empty_o && wr_ok) begin
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_comb begin
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q  <= AW'(0);
      rd_ptr_q  <= AW'(0);
      count_q   <= (AW+1)'(0);
      rd_data_q <= WIDTH'(0);
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_nxt;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// LCD pixel feeder: buffers an RGB888 stream and meters it to the panel driver
// one pixel every PIX_PERIOD clocks, padding or discarding to keep frame alignment.
module lcd_pixel_feeder
  import lcd_pkg::*;
#(
  parameter int SCREEN_W   = lcd_pkg::SCREEN_W,
  parameter int SCREEN_H   = lcd_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 512,
  parameter int PIX_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic       pix_sof,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       lcd_initialized,
  output logic       lcd_write,
  output logic [7:0] lcd_col_r,
  output logic [7:0] lcd_col_g,
  output logic [7:0] lcd_col_b,
  output logic       lcd_vblank,
  output logic       overflow_err,
  output logic       sync_err
);
  localparam int               PH_W     = $clog2(PIX_PERIOD);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PIX_PERIOD - 1);

  feeder_state_e    state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             gate_q, gate_d;
  logic             write_q, vblank_q, ovf_q, sync_q;
  rgb888_t          col_q;
  pix_entry_t       wr_entry, head;
  logic             wr_req, fifo_full, fifo_empty, fifo_flush;
  logic             pop, issue, black, sync_set, ph0;

  // The gate opens on the first SOF seen while the panel is up and stays open.
  assign gate_d     = lcd_initialized & (gate_q | (pix_valid & pix_sof));
  assign wr_req     = pix_valid & lcd_initialized & (gate_q | pix_sof);
  assign fifo_flush = ~lcd_initialized;
  assign wr_entry   = {pix_sof, pix_r, pix_g, pix_b};
  assign ph0        = (phase_q == PH_W'(0));

  sync_fifo #(
    .WIDTH($bits(pix_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (fifo_flush),
    .wr_en_i  (wr_req),
    .wr_data_i(wr_entry),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    issue    = 1'b0;
    black    = 1'b0;
    pop      = 1'b0;
    sync_set = 1'b0;
    case (state_q)
      ST_WAIT_INIT: begin
        pos_d = 18'd0;
        if (lcd_initialized) state_d = ST_WAIT_SOF;
        else                 state_d = ST_WAIT_INIT;
      end
      ST_WAIT_SOF: begin
        if (!fifo_empty && !head.sof) begin
          pop      = 1'b1;
          sync_set = 1'b1;
        end else if (!fifo_empty && ph0) begin
          issue   = 1'b1;
          pop     = 1'b1;
          pos_d   = 18'd1;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_WAIT_SOF;
        end
      end
      ST_STREAM: begin
        // At frame start only an SOF may be issued; mid-frame an SOF means the source skipped ahead.
        if (fifo_empty) begin
          state_d = ST_STREAM;
        end else if (pos_q == 18'd0 && !head.sof) begin
          pop      = 1'b1;
          sync_set = 1'b1;
        end else if (pos_q != 18'd0 && head.sof) begin
          state_d = ST_PAD;
        end else if (ph0) begin
          issue = 1'b1;
          pop   = 1'b1;
          pos_d = pos_next(pos_q, POS_LAST);
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PAD: begin
        if (ph0) begin
          issue    = 1'b1;
          black    = 1'b1;
          sync_set = 1'b1;
          pos_d    = pos_next(pos_q, POS_LAST);
          if (pos_q == POS_LAST) state_d = ST_STREAM;
          else                   state_d = ST_PAD;
        end else begin
          state_d = ST_PAD;
        end
      end
      default: state_d = ST_WAIT_INIT;
    endcase
    if (!lcd_initialized) begin
      state_d = ST_WAIT_INIT;
      pos_d   = 18'd0;
      issue   = 1'b0;
      pop     = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    if (issue)              phase_d = PH_W'(1);
    else if (ph0)           phase_d = phase_q;
    else if (phase_q == PH_LAST) phase_d = PH_W'(0);
    else                    phase_d = phase_q + PH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WAIT_INIT;
      pos_q    <= 18'd0;
      phase_q  <= PH_W'(0);
      gate_q   <= 1'b0;
      write_q  <= 1'b0;
      col_q    <= 24'd0;
      vblank_q <= 1'b1;
      ovf_q    <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      phase_q  <= phase_d;
      gate_q   <= gate_d;
      write_q  <= issue;
      if (issue) col_q <= black ? 24'd0 : head.rgb;
      vblank_q <= (pos_q == 18'd0) && !issue;
      ovf_q    <= ovf_q | (wr_req & fifo_full);
      sync_q   <= sync_q | sync_set;
    end
  end

  assign lcd_write    = write_q;
  assign lcd_col_r    = col_q.r;
  assign lcd_col_g    = col_q.g;
  assign lcd_col_b    = col_q.b;
  assign lcd_vblank   = vblank_q;
  assign overflow_err = ovf_q;
  assign sync_err     = sync_q;

endmodule

// File: doc/lcd_pixel_feeder.md
LCD_PIXEL_FEEDER -- requirements
Module: lcd_pixel_feeder

Interface
REQ-001 Parameter SCREEN_W, 320, pixels per line.
REQ-002 Parameter SCREEN_H, 240, lines per frame.
REQ-003 Parameter FIFO_DEPTH, 512, FIFO entries; power of two, at least 4.
REQ-004 Parameter PIX_PERIOD, 4, clk cycles per pixel issued to the panel driver; at least 4.
REQ-005 clk  in  1  clock, 16 MHz; same clock as the panel driver.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pix_valid  in  1  one pixel presented this cycle; there is no backpressure.
REQ-008 pix_sof  in  1  qualifies pix_valid; the pixel is frame pixel (0,0).
REQ-009 pix_r, pix_g, pix_b  in  8 each  RGB888 pixel.
REQ-010 lcd_initialized  in  1  panel driver has finished init and is accepting pixels.
REQ-011 lcd_write  out  1  one-cycle pixel strobe to the driver.
REQ-012 lcd_col_r, lcd_col_g, lcd_col_b  out  8 each  pixel to the driver.
REQ-013 lcd_vblank  out  1  high between frames.
REQ-014 overflow_err  out  1  sticky: a pixel was dropped because the FIFO was full.
REQ-015 sync_err  out  1  sticky: the feeder padded or discarded pixels to keep frame alignment.

Function
REQ-016 The input gate SHALL stay closed until lcd_initialized=1 and a pix_valid&&pix_sof pixel arrives.
- That SOF pixel SHALL be written; writes continue every pix_valid cycle thereafter.
REQ-017 Each FIFO entry SHALL be {sof, r, g, b} (25 bits).
- A write while full SHALL be dropped and SHALL set overflow_err; the FIFO contents SHALL stay unchanged.
REQ-018 The output phase counter SHALL run 0..PIX_PERIOD-1 and SHALL advance only after an issue.
- An issue SHALL be possible only at phase 0.
- Phase SHALL return to 0 exactly PIX_PERIOD cycles after the issue.
REQ-019 At an issue, lcd_write SHALL be 1 for exactly one cycle.
- lcd_col_* SHALL change only in the issue cycle and SHALL hold until the next issue.
- The driver samples lcd_col_* at issue+0 and issue+2.
REQ-020 Output FSM states: WAIT_INIT, WAIT_SOF, STREAM, PAD.
- WAIT_INIT -> WAIT_SOF when lcd_initialized=1.
REQ-021 WAIT_SOF behaviour:
- A FIFO head with sof=0 SHALL be discarded at 1 entry/cycle and SHALL set sync_err.
- A head with sof=1 SHALL be issued and SHALL set pos=1; the FSM then enters STREAM.
REQ-022 STREAM behaviour, phase 0:
- Head with sof=0: issue it and increment pos.
- Empty FIFO: no issue (underflow stall, not an error).
- Head with sof=1 while pos != 0: enter PAD.
REQ-023 PAD SHALL issue black pixels (0,0,0) at the normal cadence until pos wraps to 0, and SHALL set sync_err.
- PAD SHALL NOT pop the FIFO.
- At wrap, PAD -> STREAM.
REQ-024 pos SHALL count 0..SCREEN_W*SCREEN_H-1 (18 bits) and wrap to 0.
- Issuing at pos=0 in STREAM requires head sof=1.
- A head with sof=0 at pos=0 SHALL be discarded as in WAIT_SOF, with sync_err set.
REQ-025 lcd_vblank SHALL be 1 when pos=0 and no issue occurs that cycle; it SHALL be 0 otherwise.
REQ-026 Latency: a pixel written at cycle T into an empty FIFO, with phase 0 and a matching state, SHALL produce lcd_write at T+2.
REQ-027 A simultaneous write and pop SHALL leave the count unchanged.
- A pop while empty SHALL NOT occur.
REQ-028 If lcd_initialized falls, the FSM SHALL return to WAIT_INIT, flush the FIFO, and close the input gate.

Reset
REQ-029 Under rst the following SHALL hold:
- lcd_write=0, lcd_col_*=0, lcd_vblank=1, overflow_err=0, sync_err=0.
- FIFO empty, pos=0, phase=0, FSM=WAIT_INIT, input gate closed.
REQ-030 rst asserted mid-frame SHALL abandon the frame; no lcd_write SHALL occur in the cycle after rst is sampled.

Structure
REQ-031 Package lcd_pkg SHALL hold:
- SCREEN_W and SCREEN_H;
- the rgb888_t struct;
- the pixel-entry typedef;
- the feeder FSM state enum.
REQ-032 One sub-module, sync_fifo, SHALL be parameterised by WIDTH and DEPTH.
- It SHALL provide registered read data and full/empty flags.
- It SHALL include a flush input.

Verification
REQ-033 After init, 76800 pixels written one every 4 clocks, starting with SOF -> the bench SHALL see:
- 76800 lcd_write pulses, exactly 4 cycles apart;
- colors matching the input;
- both error flags 0.
REQ-034 Burst of 600 back-to-back pixels with FIFO_DEPTH=512 -> the bench SHALL see:
- first drop at the 513th write plus the number of entries popped by then;
- overflow_err=1 from that cycle onward.
REQ-035 Pixel (0x12,0x34,0x56) without sof, followed by an SOF pixel -> the bench SHALL see:
- the first pixel discarded, sync_err=1;
- the first lcd_write carries the SOF pixel's color.
REQ-036 New SOF after 100 pixels of a frame -> the bench SHALL see:
- 76700 black pads issued, sync_err=1;
- then the SOF pixel issued with pos=1 afterward.
REQ-037 Empty FIFO mid-frame for 40 cycles -> the bench SHALL see:
- no lcd_write and lcd_vblank=0 during the gap;
- streaming resumes without error.
REQ-038 rst pulsed at pos=5000 -> the bench SHALL see:
- all outputs at their reset values the following cycle;
- no output until lcd_initialized and a new SOF arrive.
